mem_arbiter: RTL and testbench

//  Requester side of cpu_ram_if: drives ramREN/ramWEN/ramaddr/ramstore and consumes ramload/ramstate.

---
 rtl/cpu_types_pkg.sv | 42 ++++
 rtl/mem_arbiter_req_timer.sv | 46 ++++
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
//   Shared types for the single-cycle datapath and its RAM interface.
//   word_t       : 32-bit machine word
//   ramstate_t   : status reported by the RAM on every cycle
//   arbstate_t   : state of the fetch/data arbiter in front of the RAM
//   Defaults for the arbiter timeout and the poison value returned on a
//   failed access, plus a helper that detects an owner changing its request.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DGRANT = 2'b01,
    IGRANT = 2'b10
  } arbstate_t;

  localparam int    TIMEOUT_DEFAULT = 16;
  localparam word_t BADLOAD_DEFAULT = 32'hBAD1BAD1;

  // True when the live request no longer matches what was latched at grant.
  function automatic logic req_moved(
    input logic  ren_now,
    input logic  wen_now,
    input word_t addr_now,
    input logic  ren_lat,
    input logic  wen_lat,
    input word_t addr_lat
  );
    return (ren_now != ren_lat) || (wen_now != wen_lat) || (addr_now != addr_lat);
  endfunction

endpackage

// File: rtl/mem_arbiter_req_timer.sv
// ---------------------------------------------------------------------------
// req_timer
//   Counts cycles a granted request has been waiting on the RAM.
//   Ports:
//     CLK       clock, rising edge
//     nRST      synchronous active-low reset
//     clr_i     force count to zero (has priority over en_i)
//     en_i      advance count by one
//     expire_o  count has reached TIMEOUT-1
//   The count saturates at TIMEOUT-1 so expire_o stays asserted if the
//   arbiter ever lingers there.
// ---------------------------------------------------------------------------
module req_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [TW-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one RAM between the instruction-fetch and data ports of the
//   single-cycle datapath. Data requests win over fetches. A granted request
//   is latched and replayed to the RAM unchanged until the RAM reports
//   ACCESS; a request that hangs (timer expiry or RAM ERROR) is completed
//   with BADLOAD and flags the sticky memerr.
//
//   Ports:
//     CLK, nRST                  clock / synchronous active-low reset
//     iREN, iaddr                fetch request and word address
//     iload, iwait               fetched word / fetch stall
//     dREN, dWEN, daddr, dstore  data read/write request, address, write data
//     dload, dwait               read data / data stall
//     ramREN, ramWEN, ramaddr,
//     ramstore                   request to the RAM
//     ramload, ramstate          response from the RAM
//     memerr                     sticky error flag, cleared only by reset
//
//   state  | meaning
//   IDLE   | arbitrate; winner drives the RAM directly, may complete at once
//   DGRANT | data port owns the RAM, driven from latched regs
//   IGRANT | fetch port owns the RAM, driven from latched regs
// ---------------------------------------------------------------------------
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int    TIMEOUT = TIMEOUT_DEFAULT,
  parameter word_t BADLOAD = BADLOAD_DEFAULT
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      memerr
);

  arbstate_t state_q, state_d;
  logic      ren_q, ren_d;
  logic      wen_q, wen_d;
  word_t     addr_q, addr_d;
  word_t     store_q, store_d;
  logic      memerr_q, memerr_d;

  logic d_req, i_req;
  logic abort;
  logic d_done, i_done, d_bad, i_bad;
  logic tmr_clr, tmr_en, tmr_expire;

  assign d_req = dREN | dWEN;
  assign i_req = iREN;

  req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK      (CLK),
    .nRST     (nRST),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  // RAM drive and request latch. Kept apart from the ramstate-dependent
  // logic below: the RAM's status depends on what we drive, never the reverse.
  always_comb begin
    ren_d    = ren_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    store_d  = store_q;
    abort    = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = addr_q;
    ramstore = store_q;

    case (state_q)
      IDLE: begin
        if (d_req) begin
          ren_d   = dREN;
          wen_d   = dWEN;
          addr_d  = daddr;
          store_d = dstore;
        end else if (i_req) begin
          ren_d   = 1'b1;
          wen_d   = 1'b0;
          addr_d  = iaddr;
          store_d = '0;
        end
        if (d_req || i_req) begin
          ramREN   = ren_d;
          ramWEN   = wen_d;
          ramaddr  = addr_d;
          ramstore = store_d;
        end
      end
      DGRANT: abort = req_moved(dREN, dWEN, daddr, ren_q, wen_q, addr_q);
      IGRANT: abort = req_moved(iREN, 1'b0, iaddr, ren_q, wen_q, addr_q);
      default: abort = 1'b0;
    endcase

    // Granted: replay the latched request; on abort release the RAM.
    if (state_q != IDLE && !abort) begin
      ramREN = ren_q;
      ramWEN = wen_q;
    end

    if (!nRST) begin
      ramREN = 1'b0;
      ramWEN = 1'b0;
    end
  end

  // Next state, completion and error detection.
  always_comb begin
    state_d  = state_q;
    memerr_d = memerr_q;
    d_done   = 1'b0;
    i_done   = 1'b0;
    d_bad    = 1'b0;
    i_bad    = 1'b0;
    tmr_clr  = 1'b1;
    tmr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req) begin
          if (ramstate == ACCESS) d_done = 1'b1;
          else                    state_d = DGRANT;
        end else if (i_req) begin
          if (ramstate == ACCESS) i_done = 1'b1;
          else                    state_d = IGRANT;
        end
      end
      DGRANT: begin
        tmr_clr = 1'b0;
        tmr_en  = 1'b1;
        state_d = IDLE;
        if (abort) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          d_done = 1'b1;
        end else if (ramstate == ERROR || tmr_expire) begin
          d_bad    = 1'b1;
          memerr_d = 1'b1;
        end else begin
          state_d = DGRANT;
        end
      end
      IGRANT: begin
        tmr_clr = 1'b0;
        tmr_en  = 1'b1;
        state_d = IDLE;
        if (abort) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          i_done = 1'b1;
        end else if (ramstate == ERROR || tmr_expire) begin
          i_bad    = 1'b1;
          memerr_d = 1'b1;
        end else begin
          state_d = IGRANT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      memerr_q <= memerr_d;
    end
  end

  // A port that is not requesting never stalls and sees the poison value.
  assign dwait  = !nRST ? 1'b1 : (d_req && !(d_done || d_bad));
  assign iwait  = !nRST ? 1'b1 : (i_req && !(i_done || i_bad));
  assign dload  = d_done ? ramload : BADLOAD;
  assign iload  = i_done ? ramload : BADLOAD;
  assign memerr = memerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK;
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      memerr;

  int errors = 0;
  int checks = 0;
  int n;

  mem_arbiter #(
    .TIMEOUT (4),
    .BADLOAD (32'hBAD1BAD1)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .memerr   (memerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model: ACCESS once the same request has been held for lat cycles
  // after its first cycle. Unwritten words read as 0x10000000 | word index.
  int          lat = 0;
  logic        force_err = 1'b0;
  logic        prev_ren_q = 1'b0;
  logic        prev_wen_q = 1'b0;
  word_t       prev_addr_q = '0;
  int          cnt_q = 0;
  int          cur_cnt;
  logic        same;
  logic [7:0]  ridx;
  logic [255:0] wr_valid = '0;
  word_t       wmem [256];

  assign ridx    = 8'((ramaddr >> 2) & 32'hFF);
  assign ramload = wr_valid[ridx] ? wmem[ridx] : (32'h1000_0000 | 32'(ridx));

  always_comb begin
    same    = (prev_ren_q | prev_wen_q) && (ramaddr == prev_addr_q) &&
              (ramREN == prev_ren_q) && (ramWEN == prev_wen_q);
    cur_cnt = same ? cnt_q : 0;
    if (!(ramREN | ramWEN))  ramstate = FREE;
    else if (force_err)      ramstate = ERROR;
    else if (cur_cnt >= lat) ramstate = ACCESS;
    else                     ramstate = BUSY;
  end

  always @(posedge CLK) begin
    prev_ren_q  <= ramREN;
    prev_wen_q  <= ramWEN;
    prev_addr_q <= ramaddr;
    if ((ramREN | ramWEN) && ramstate != ACCESS) cnt_q <= cur_cnt + 1;
    else                                         cnt_q <= 0;
    if (ramWEN && ramstate == ACCESS) begin
      wmem[ridx]     <= ramstore;
      wr_valid[ridx] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_d(input int max, output int cyc);
    cyc = 0;
    #1;
    while (dwait !== 1'b0 && cyc < max) begin
      tick();
      #1;
      cyc++;
    end
  endtask

  task automatic wait_i(input int max, output int cyc);
    cyc = 0;
    #1;
    while (iwait !== 1'b0 && cyc < max) begin
      tick();
      #1;
      cyc++;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; iREN = 1'b1; iaddr = '0; dREN = 1'b1; dWEN = 1'b0;
    daddr = 32'h40; dstore = '0;
    #1;
    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_iwait",  32'(iwait),  1);
    chk("rst_dwait",  32'(dwait),  1);
    tick();
    chk("rst_memerr", 32'(memerr), 0);
    chk("rst_state",  32'(dut.state_q), 32'(IDLE));
    nRST = 1'b1; iREN = 1'b0; dREN = 1'b0;
    tick();

    // Zero-latency fetch
    lat = 0; iREN = 1'b1; iaddr = 32'h0;
    #1;
    chk("zl_iwait",  32'(iwait),  0);
    chk("zl_iload",  iload,       32'h1000_0000);
    chk("zl_ramREN", 32'(ramREN), 1);
    tick();
    chk("zl_state",  32'(dut.state_q), 32'(IDLE));
    iREN = 1'b0;

    // Data wins over fetch, LAT=3
    lat = 3; dREN = 1'b1; daddr = 32'h40; iREN = 1'b1; iaddr = 32'h8;
    #1;
    chk("pri_ramaddr", ramaddr,      32'h40);
    chk("pri_dwait0",  32'(dwait),   1);
    chk("pri_iwait0",  32'(iwait),   1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      #1;
      chk("pri_iwait", 32'(iwait), 1);
      chk("pri_dwait", 32'(dwait), (k < 3) ? 32'd1 : 32'd0);
    end
    chk("pri_dload", dload, 32'h1000_0010);
    tick();
    dREN = 1'b0;
    #1;
    chk("fetch_ramaddr", ramaddr,    32'h8);
    chk("fetch_ramREN",  32'(ramREN), 1);
    chk("idle_dwait",    32'(dwait),  0);
    chk("idle_dload",    dload,       32'hBAD1BAD1);
    wait_i(10, n);
    chk("fetch_lat",   32'(n), 3);
    chk("fetch_iload", iload,  32'h1000_0002);
    tick();
    iREN = 1'b0;

    // Write then read back, LAT=2
    lat = 2; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hCAFE_F00D;
    #1;
    chk("wr_ramWEN",   32'(ramWEN), 1);
    chk("wr_ramREN",   32'(ramREN), 0);
    chk("wr_ramstore", ramstore,    32'hCAFE_F00D);
    wait_d(10, n);
    chk("wr_lat", 32'(n), 2);
    tick();
    dWEN = 1'b0; dREN = 1'b1;
    wait_d(10, n);
    chk("rd_lat",   32'(n), 2);
    chk("rd_dload", dload,  32'hCAFE_F00D);
    tick();
    dREN = 1'b0;

    // Address changes mid-grant: abort, then regrant
    lat = 2; dREN = 1'b1; daddr = 32'h40;
    #1;
    chk("ab_ramREN0", 32'(ramREN), 1);
    tick();
    daddr = 32'h44;
    #1;
    chk("ab_ramREN",  32'(ramREN), 0);
    chk("ab_dwait",   32'(dwait),  1);
    tick();
    #1;
    chk("ab_ramaddr", ramaddr,      32'h44);
    chk("ab_ramREN1", 32'(ramREN),  1);
    wait_d(10, n);
    chk("ab_lat",   32'(n), 2);
    chk("ab_dload", dload,  32'h1000_0011);
    tick();
    dREN = 1'b0;

    // Timeout: RAM too slow for TIMEOUT=4
    lat = 15; dREN = 1'b1; daddr = 32'h100;
    #1;
    chk("to_memerr0", 32'(memerr), 0);
    wait_d(10, n);
    chk("to_lat",     32'(n),      4);
    chk("to_dload",   dload,       32'hBAD1BAD1);
    chk("to_memerr1", 32'(memerr), 0);
    tick();
    dREN = 1'b0;
    #1;
    chk("to_memerr2", 32'(memerr), 1);
    chk("to_dwait",   32'(dwait),  0);
    tick();
    tick();
    chk("to_memerr3", 32'(memerr), 1);

    // RAM ERROR during a fetch grant
    lat = 15; iREN = 1'b1; iaddr = 32'hC;
    #1;
    chk("er_iwait0", 32'(iwait), 1);
    tick();
    force_err = 1'b1;
    #1;
    chk("er_iwait", 32'(iwait), 0);
    chk("er_iload", iload,      32'hBAD1BAD1);
    tick();
    force_err = 1'b0; iREN = 1'b0;
    tick();

    // Reset during IGRANT
    lat = 15; iREN = 1'b1; iaddr = 32'h10;
    #1;
    tick();
    #1;
    chk("rg_state",  32'(dut.state_q), 32'(IGRANT));
    chk("rg_ramREN", 32'(ramREN),      1);
    nRST = 1'b0;
    #1;
    chk("rg_ramREN_rst", 32'(ramREN), 0);
    chk("rg_iwait_rst",  32'(iwait),  1);
    tick();
    chk("rg_state_idle", 32'(dut.state_q), 32'(IDLE));
    chk("rg_memerr",     32'(memerr),      0);
    chk("rg_ramREN2",    32'(ramREN),      0);
    nRST = 1'b1; iREN = 1'b0;
    #1;
    chk("rg_iwait_idle", 32'(iwait), 0);
    chk("rg_iload_idle", iload,      32'hBAD1BAD1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
